my_if_sink: RTL and testbench



---
 rtl/my_if_pkg.sv | 14 +
 rtl/my_if_sink_fifo.sv | 72 +++++++
 rtl/my_if_sink.sv | 92 +++++++++
 tb/tb_my_if_sink.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/my_if_pkg.sv
package my_if_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TOTAL_W = 16;

  typedef enum logic {
    SINK_RUN,
    SINK_DRAIN
  } sink_state_e;

  typedef logic [DATA_W-1:0]  byte_t;
  typedef logic [TOTAL_W-1:0] total_t;

endpackage

// File: rtl/my_if_sink_fifo.sv
module my_if_sink_fifo
  import my_if_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    pop,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned     AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    rd_data = mem_q[rd_ptr_q];
    count   = count_q;
  end

  // Pointers are exactly AW bits wide, so DEPTH being a power of two makes wrap free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/my_if_sink.sv
module my_if_sink
  import my_if_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    busy_drain,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             byte_total,
  output logic [DATA_W-1:0]       checksum
);

  sink_state_e       state_q, state_d;
  total_t            byte_total_q, byte_total_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              push, pop;
  logic              fifo_full, fifo_empty;

  // in_ready is deliberately independent of out_ready: a full FIFO never pushes.
  always_comb begin
    in_ready   = (state_q == SINK_RUN) && !fifo_full && !rst;
    out_valid  = !fifo_empty;
    push       = in_valid && in_ready;
    pop        = out_valid && out_ready;
    busy_drain = (state_q == SINK_DRAIN);
    byte_total = byte_total_q;
    checksum   = checksum_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SINK_RUN: begin
        if (flush) begin
          state_d = SINK_DRAIN;
        end
      end
      SINK_DRAIN: begin
        if (fifo_empty) begin
          state_d = SINK_RUN;
        end
      end
      default: state_d = SINK_RUN;
    endcase
  end

  always_comb begin
    byte_total_d = byte_total_q;
    checksum_d   = checksum_q;
    if (push) begin
      byte_total_d = byte_total_q + 1'b1;
      checksum_d   = checksum_q ^ in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SINK_RUN;
      byte_total_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      byte_total_q <= byte_total_d;
      checksum_q   <= checksum_d;
    end
  end

  my_if_sink_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

endmodule

// File: tb/tb_my_if_sink.sv
module tb_my_if_sink;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              flush;
  logic              busy_drain;
  logic [CW-1:0]     count;
  logic [15:0]       byte_total;
  logic [DATA_W-1:0] checksum;

  always #5 clk = ~clk;

  my_if_sink #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush      (flush),
    .busy_drain (busy_drain),
    .count      (count),
    .byte_total (byte_total),
    .checksum   (checksum)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference: a byte queue plus "draining" flag, totals kept as plain arithmetic.
  logic [7:0]  mq[$];
  bit          m_drain;
  logic [15:0] m_total;
  logic [7:0]  m_csum;

  typedef struct {
    bit         r, iv;
    logic [7:0] d;
    bit         o, f;
    bit         e_ir, e_ov;
    logic [7:0] e_od;
    logic [2:0] e_cnt;
    bit         e_busy;
    logic [15:0] e_tot;
    logic [7:0] e_cs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, input bit iv, input logic [7:0] d, input bit o, input bit f,
                     input bit eir, input bit eov, input logic [7:0] eod, input logic [2:0] ecnt,
                     input bit eb, input logic [15:0] et, input logic [7:0] ecs);
    vec_t v;
    v = '{r: r, iv: iv, d: d, o: o, f: f, e_ir: eir, e_ov: eov, e_od: eod,
          e_cnt: ecnt, e_busy: eb, e_tot: et, e_cs: ecs};
    tbl.push_back(v);
  endtask

  task automatic cyc(input bit r, input bit iv, input logic [7:0] d, input bit o, input bit f,
                     input bit cmp);
    bit m_ir;
    bit was_empty;
    rst = r; in_valid = iv; in_data = d; out_ready = o; flush = f;
    #1;
    m_ir = !r && !m_drain && (mq.size() < DEPTH);
    if (cmp) begin
      chk("in_ready", 32'(in_ready), 32'(m_ir));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
      chk("count", 32'(count), 32'(mq.size()));
      chk("busy_drain", 32'(busy_drain), 32'(m_drain));
      chk("byte_total", 32'(byte_total), 32'(m_total));
      chk("checksum", 32'(checksum), 32'(m_csum));
    end
    if (r) begin
      mq.delete();
      m_drain = 1'b0;
      m_total = '0;
      m_csum  = '0;
    end else begin
      was_empty = (mq.size() == 0);
      if (!was_empty && o) void'(mq.pop_front());
      if (m_ir && iv) begin
        mq.push_back(d);
        m_total = m_total + 16'd1;
        m_csum  = m_csum ^ d;
      end
      if (!m_drain) m_drain = f;
      else if (was_empty) m_drain = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_drain[3];
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    m_drain = 1'b0; m_total = '0; m_csum = '0;

    //  r     iv    d      o     f     ir    ov    od     cnt   busy  total   csum
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 16'd0, 8'h00);
    add(1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 16'd0, 8'h00);
    add(1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0, 16'd1, 8'h11);
    add(1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 3'd1, 1'b0, 16'd2, 8'h33);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 3'd1, 1'b0, 16'd3, 8'h00);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 16'd3, 8'h00);
    add(1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 16'd3, 8'h00);
    add(1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd1, 1'b0, 16'd4, 8'hA0);
    add(1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd2, 1'b0, 16'd5, 8'h01);
    add(1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd3, 1'b0, 16'd6, 8'hA3);
    add(1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 3'd4, 1'b0, 16'd7, 8'h00);
    add(1'b0, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 3'd4, 1'b0, 16'd7, 8'h00);
    add(1'b0, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd3, 1'b0, 16'd7, 8'h00);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 3'd3, 1'b0, 16'd8, 8'hA4);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 3'd2, 1'b0, 16'd8, 8'hA4);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, 3'd1, 1'b0, 16'd8, 8'hA4);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 16'd8, 8'hA4);

    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      rst = tbl[i].r; in_valid = tbl[i].iv; in_data = tbl[i].d;
      out_ready = tbl[i].o; flush = tbl[i].f;
      #1;
      chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].e_ir));
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk("tbl_out_data", 32'(out_data), 32'(tbl[i].e_od));
      chk("tbl_count", 32'(count), 32'(tbl[i].e_cnt));
      chk("tbl_busy", 32'(busy_drain), 32'(tbl[i].e_busy));
      chk("tbl_total", 32'(byte_total), 32'(tbl[i].e_tot));
      chk("tbl_csum", 32'(checksum), 32'(tbl[i].e_cs));
      cyc(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].o, tbl[i].f, 1'b0);
    end

    // Flush at count 2 with a same-cycle push of 0xAA.
    cyc(1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);
    chk("flush_busy", 32'(busy_drain), 32'd1);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_count", 32'(count), 32'd3);
    exp_drain[0] = 8'hB1; exp_drain[1] = 8'hB2; exp_drain[2] = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      chk("drain_data", 32'(out_data), 32'(exp_drain[i]));
      chk("drain_busy", 32'(busy_drain), 32'd1);
      cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    end
    chk("drain_empty_count", 32'(count), 32'd0);
    chk("drain_empty_busy", 32'(busy_drain), 32'd1);
    cyc(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    chk("drain_exit_busy", 32'(busy_drain), 32'd0);
    chk("drain_exit_ready", 32'(in_ready), 32'd1);

    // Flush with an empty FIFO: exactly one DRAIN cycle.
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("eflush_busy", 32'(busy_drain), 32'd1);
    chk("eflush_ready", 32'(in_ready), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("eflush_exit_busy", 32'(busy_drain), 32'd0);
    chk("eflush_exit_ready", 32'(in_ready), 32'd1);

    // Reset in DRAIN with three bytes buffered.
    cyc(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'hC2, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("rdrain_busy", 32'(busy_drain), 32'd1);
    chk("rdrain_count", 32'(count), 32'd3);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_total", 32'(byte_total), 32'd0);
    chk("rst_busy", 32'(busy_drain), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(in_ready), 32'd1);

    // byte_total wrap.
    for (int i = 0; i < 65535; i++) begin
      cyc(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    end
    chk("total_ffff", 32'(byte_total), 32'h0000_FFFF);
    chk("total_csum", 32'(checksum), 32'(m_csum));
    cyc(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
    chk("total_wrap", 32'(byte_total), 32'd0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(199) == 0, $urandom_range(3) != 0, 8'($urandom),
          $urandom_range(2) != 0, $urandom_range(15) == 0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
